uart_mmio: RTL and testbench

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: DATA/STATUS/CTRL registers, TX and RX FIFOs, optional
// internal loopback. Bus strobes are edge-detected so held strobes act once.
module uart_mmio #(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_ren,
  input  logic        uart_wen,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] uart_out,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BaudLast = CW'(DIV - 1);
  localparam logic [CW-1:0] HalfLast = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BaudOne  = CW'(1);
  localparam logic [AW:0]   PtrOne   = (AW + 1)'(1);
  localparam logic [AW:0]   PtrFull  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Bus decode
  logic ren_q, wen_q, ren_edge, wen_edge;
  logic sel_data, sel_stat, sel_ctrl;
  logic rd_data, rd_stat, wr_ctrl;
  logic wr_pend_q;
  logic [7:0] wr_byte_q;
  logic loopback_q;
  logic unused_wdata;

  assign ren_edge = uart_ren & ~ren_q;
  assign wen_edge = uart_wen & ~wen_q;
  assign sel_data = (addr == 4'h0);
  assign sel_stat = (addr == 4'h4);
  assign sel_ctrl = (addr == 4'h8);
  assign rd_data  = ren_edge & sel_data;
  assign rd_stat  = ren_edge & sel_stat;
  assign wr_ctrl  = wen_edge & sel_ctrl;
  assign unused_wdata = ^wdata[31:8];

  // TX FIFO
  logic [7:0]  txf_mem [FIFO_DEPTH];
  logic [AW:0] txf_wp_q, txf_rp_q;
  logic        txf_empty, txf_full, txf_push, txf_pop;

  assign txf_empty = (txf_wp_q == txf_rp_q);
  assign txf_full  = ((txf_wp_q - txf_rp_q) == PtrFull);
  assign txf_push  = wr_pend_q & (~txf_full | txf_pop);

  // TX FSM
  logic [1:0]    tx_st_q, tx_st_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d, tx_load, tx_busy;

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    if (tx_st_q == StIdle) begin
      tx_load = ~txf_empty;
    end else if (tx_baud_q == BaudLast) begin
      tx_baud_d = '0;
      case (tx_st_q)
        StStart: begin
          tx_st_d  = StData;
          tx_bit_d = 3'd0;
          tx_d     = tx_shift_q[0];
        end
        StData: begin
          if (tx_bit_q == 3'd7) begin
            tx_st_d = StStop;
            tx_d    = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
        default: begin
          // Chain straight into the next start bit so bytes go out back to back
          tx_st_d = StIdle;
          tx_load = ~txf_empty;
        end
      endcase
    end else begin
      tx_baud_d = tx_baud_q + BaudOne;
    end
    if (tx_load) begin
      tx_st_d    = StStart;
      tx_baud_d  = '0;
      tx_shift_d = txf_mem[txf_rp_q[AW-1:0]];
      tx_d       = 1'b0;
    end
  end

  assign txf_pop = tx_load;
  assign tx_busy = ~txf_empty | (tx_st_q != StIdle);
  assign tx      = tx_q;

  // RX synchronizer and FSM
  logic          sync1_q, sync2_q, rx_prev_q, rx_fall;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_push_req, frame_set;

  assign rx_fall = rx_prev_q & ~sync2_q;

  always_comb begin
    rx_st_d     = rx_st_q;
    rx_baud_d   = rx_baud_q + BaudOne;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push_req = 1'b0;
    frame_set   = 1'b0;
    case (rx_st_q)
      StIdle: begin
        rx_baud_d = '0;
        if (rx_fall) rx_st_d = StStart;
      end
      StStart: begin
        if (rx_baud_q == HalfLast) begin
          rx_baud_d = '0;
          rx_bit_d  = 3'd0;
          rx_st_d   = sync2_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = StStop;
        end
      end
      default: begin
        // On a bad stop bit the fall detector needs the line high again before
        // another start is accepted, which covers waiting for rx to go high.
        if (rx_baud_q == BaudLast) begin
          rx_baud_d   = '0;
          rx_st_d     = StIdle;
          rx_push_req = sync2_q;
          frame_set   = ~sync2_q;
        end
      end
    endcase
  end

  // RX FIFO
  logic [7:0]  rxf_mem [FIFO_DEPTH];
  logic [AW:0] rxf_wp_q, rxf_rp_q;
  logic        rxf_empty, rxf_full, rxf_push, rxf_pop, overrun_set;
  logic        overrun_q, frame_err_q;

  assign rxf_empty   = (rxf_wp_q == rxf_rp_q);
  assign rxf_full    = ((rxf_wp_q - rxf_rp_q) == PtrFull);
  assign rxf_pop     = rd_data & ~rxf_empty;
  assign rxf_push    = rx_push_req & (~rxf_full | rxf_pop);
  assign overrun_set = rx_push_req & rxf_full & ~rxf_pop;

  always_comb begin
    uart_out = '0;
    case (addr)
      4'h0:    uart_out = rxf_empty ? 32'd0 : {24'd0, rxf_mem[rxf_rp_q[AW-1:0]]};
      4'h4:    uart_out = {27'd0, frame_err_q, overrun_q, tx_busy, txf_full, ~rxf_empty};
      4'h8:    uart_out = {31'd0, loopback_q};
      default: uart_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_byte_q   <= '0;
      loopback_q  <= 1'b0;
      txf_wp_q    <= '0;
      txf_rp_q    <= '0;
      tx_st_q     <= StIdle;
      tx_baud_q   <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_st_q     <= StIdle;
      rx_baud_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rxf_wp_q    <= '0;
      rxf_rp_q    <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ren_q       <= uart_ren;
      wen_q       <= uart_wen;
      wr_pend_q   <= wen_edge & sel_data;
      if (wen_edge & sel_data) wr_byte_q <= wdata[7:0];
      if (wr_ctrl) loopback_q <= wdata[0];
      if (txf_push) txf_wp_q <= txf_wp_q + PtrOne;
      if (txf_pop) txf_rp_q <= txf_rp_q + PtrOne;
      tx_st_q     <= tx_st_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      sync1_q     <= loopback_q ? tx_q : rx;
      sync2_q     <= sync1_q;
      rx_prev_q   <= sync2_q;
      rx_st_q     <= rx_st_d;
      rx_baud_q   <= rx_baud_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      if (rxf_push) rxf_wp_q <= rxf_wp_q + PtrOne;
      if (rxf_pop) rxf_rp_q <= rxf_rp_q + PtrOne;
      overrun_q   <= overrun_set | (overrun_q & ~rd_stat);
      frame_err_q <= frame_set | (frame_err_q & ~rd_stat);
    end
  end

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem[txf_wp_q[AW-1:0]] <= wr_byte_q;
    if (rxf_push) rxf_mem[rxf_wp_q[AW-1:0]] <= rx_shift_q;
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized bench for uart_mmio (DIV=4): queue-based UART model plus a line-level
// frame decoder on tx.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_ren = 1'b0;
  logic        uart_wen = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = '0;
  logic [31:0] uart_out;
  logic        tx;
  logic        rx = 1'b1;

  always #5 clk = ~clk;

  uart_mmio #(
    .CLK_FREQ  (4),
    .BAUD      (1),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_ren (uart_ren),
    .uart_wen (uart_wen),
    .addr     (addr),
    .wdata    (wdata),
    .uart_out (uart_out),
    .tx       (tx),
    .rx       (rx)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model state: RX FIFO contents and sticky flags
  logic [7:0] rxq[$];
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;

  // Line decoder for tx (samples mid-bit on falling clock edges)
  logic [7:0] tx_seen[$];
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (tx == 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 2 && tx) mon_act = 1'b0;
        else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt - 6) % 4 == 0)
          mon_byte[(mon_cnt - 6) / 4] = tx;
        else if (mon_cnt == 38) begin
          check_eq("tx_stop_bit", {31'd0, tx}, 32'd1);
          tx_seen.push_back(mon_byte);
          mon_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_rx_byte(input logic [7:0] b);
    if (rxq.size() < 8) rxq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr = a;
    uart_ren = 1'b1;
    #1 d = uart_out;
    @(negedge clk);
    uart_ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] v);
    addr = a;
    wdata = v;
    uart_wen = 1'b1;
    @(negedge clk);
    uart_wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_data(input string tag);
    logic [31:0] d, exp;
    exp = (rxq.size() > 0) ? {24'd0, rxq.pop_front()} : 32'd0;
    bus_read(4'h0, d);
    check_eq(tag, d, exp);
  endtask

  // Only used while the transmitter is idle, so tx_busy/tx_full are expected 0
  task automatic check_status(input string tag);
    logic [31:0] d, exp;
    exp = {27'd0, m_fe, m_ovr, 1'b0, 1'b0, rxq.size() > 0};
    bus_read(4'h4, d);
    check_eq(tag, d, exp);
    m_fe = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (4) @(negedge clk);
    end
    rx = stop_bit;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    if (stop_bit) model_rx_byte(b);
    else m_fe = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    addr = 4'h4;
    #1;
    while ((uart_out[2] || mon_act) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_idle_wait"}, {31'd0, n < 2000}, 32'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_tx_seen(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_count"}, tx_seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < tx_seen.size(); i++)
      check_eq({tag, "_byte"}, {24'd0, tx_seen[i]}, {24'd0, exp[i]});
    tx_seen.delete();
  endtask

  task automatic tx_round(input string tag, input logic lb);
    logic [7:0] exp[$];
    int n;
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      exp.push_back(8'($urandom));
      bus_write(4'h0, {24'd0, exp[i]});
      if (lb) model_rx_byte(exp[i]);
    end
    wait_idle(tag);
    check_tx_seen(tag, exp);
    if (lb) begin
      check_status({tag, "_st"});
      for (int i = 0; i <= n; i++) check_data({tag, "_data"});
      check_status({tag, "_st2"});
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0] exp[$];
    logic [7:0] b;
    logic etx, ebusy;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    addr = 4'h4;
    #1 check_eq("rst_status", uart_out, 32'd0);
    addr = 4'h0;
    #1 check_eq("rst_data", uart_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55 frame: exact waveform, 2-clock latency and tx_busy span
    b = 8'h55;
    addr = 4'h0;
    wdata = 32'h55;
    uart_wen = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 1) begin
        uart_wen = 1'b0;
        addr = 4'h4;
      end
      #1;
      if (k >= 3 && k <= 6) etx = 1'b0;
      else if (k >= 7 && k <= 38) etx = b[(k - 7) / 4];
      else etx = 1'b1;
      ebusy = (k >= 2 && k <= 42);
      check_eq("wave_tx", {31'd0, tx}, {31'd0, etx});
      check_eq("wave_busy", {31'd0, uart_out[2]}, {31'd0, ebusy});
    end
    exp = '{8'h55};
    wait_idle("wave");
    check_tx_seen("wave", exp);

    // Loopback with 0xA3
    bus_write(4'h8, 32'h1);
    bus_read(4'h8, d);
    check_eq("ctrl_read", d, 32'd1);
    bus_read(4'hC, d);
    check_eq("reserved_read", d, 32'd0);
    bus_write(4'h0, 32'hA3);
    model_rx_byte(8'hA3);
    wait_idle("lb_a3");
    exp = '{8'hA3};
    check_tx_seen("lb_a3_pin", exp);
    check_status("lb_a3_st");
    check_data("lb_a3_data");
    check_data("lb_a3_empty");
    check_status("lb_a3_st2");

    for (int r = 0; r < 3; r++) tx_round("lb_rand", 1'b1);
    bus_write(4'h8, 32'h0);
    for (int r = 0; r < 3; r++) tx_round("tx_rand", 1'b0);

    // Nine writes while a frame is in flight: ninth dropped
    exp.delete();
    b = 8'($urandom);
    exp.push_back(b);
    bus_write(4'h0, {24'd0, b});
    repeat (4) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) exp.push_back(b);
      bus_write(4'h0, {24'd0, b});
      addr = 4'h4;
      #1;
      if (i >= 7) check_eq("burst_full", {31'd0, uart_out[1]}, 32'd1);
      else check_eq("burst_notfull", {31'd0, uart_out[1]}, 32'd0);
    end
    wait_idle("burst");
    check_tx_seen("burst", exp);

    // Nine received frames with no reads: overrun
    for (int i = 0; i < 9; i++) send_frame(8'($urandom), 1'b1);
    check_status("ovr_st");
    check_status("ovr_st2");
    for (int i = 0; i < 9; i++) check_data("ovr_drain");

    // Bad stop bit, then a 1-clock glitch
    send_frame(8'($urandom), 1'b0);
    check_status("fe_st");
    check_status("fe_st2");
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_status("glitch_st");
    check_data("glitch_data");

    // Random mix of frames and register reads
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) send_frame(8'($urandom), $urandom_range(0, 7) != 0);
      else if (r < 8) check_data("mix_data");
      else check_status("mix_st");
    end
    while (rxq.size() > 0) check_data("mix_drain");
    check_status("mix_end");

    // Held read strobe pops once; held write strobe pushes once
    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b1);
    addr = 4'h0;
    uart_ren = 1'b1;
    repeat (5) @(negedge clk);
    uart_ren = 1'b0;
    @(negedge clk);
    void'(rxq.pop_front());
    check_data("hold_ren_data");
    check_data("hold_ren_empty");
    b = 8'($urandom);
    addr = 4'h0;
    wdata = {24'd0, b};
    uart_wen = 1'b1;
    repeat (5) @(negedge clk);
    uart_wen = 1'b0;
    wait_idle("hold_wen");
    exp = '{b};
    check_tx_seen("hold_wen", exp);

    // Reset mid-frame in loopback
    bus_write(4'h8, 32'h1);
    bus_write(4'h0, 32'h00);
    repeat (12) @(negedge clk);
    check_eq("pre_rst_tx", {31'd0, tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_tx_async", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rxq.delete();
    m_ovr = 1'b0;
    m_fe = 1'b0;
    tx_seen.delete();
    repeat (60) @(negedge clk);
    check_eq("post_rst_frames", tx_seen.size(), 32'd0);
    check_status("post_rst_st");
    check_data("post_rst_data");
    bus_read(4'h8, d);
    check_eq("post_rst_ctrl", d, 32'd0);
    tx_round("post_rst_tx", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
